apb_periph_arbiter: RTL
=======================

Name: apb_periph_arbiter

Overview:
- Shares the single APB slave port of the peripheral bus (address decoder plus peripheral fan-out) between NUM_REQ APB requesters, e.g. the host AXI-to-APB bridge and the debug/cluster bridge.
- Round-robin arbitration with one transfer in flight.
- Provides a per-transfer response timeout, so a hung peripheral returns PSLVERR instead of stalling the host.

Parameters:
- NUM_REQ, 2, number of APB requester ports (>=2)
- APB_ADDR_WIDTH, 32, address width
- APB_DATA_WIDTH, 32, data width (PSTRB width = APB_DATA_WIDTH/8)
- TIMEOUT_CYCLES, 1024, max ACCESS-phase cycles before forced error; 0 disables timeout
- CNT_WIDTH, 16, timeout counter width; TIMEOUT_CYCLES must be < 2**CNT_WIDTH

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_paddr_i  in  NUM_REQ x APB_ADDR_WIDTH  requester addresses
- req_pwdata_i  in  NUM_REQ x APB_DATA_WIDTH  requester write data
- req_pwrite_i  in  NUM_REQ  requester write flags
- req_pstrb_i  in  NUM_REQ x APB_DATA_WIDTH/8  requester strobes
- req_pprot_i  in  NUM_REQ x 3  requester protection
- req_psel_i  in  NUM_REQ  requester selects
- req_penable_i  in  NUM_REQ  requester enables
- req_pready_o  out  NUM_REQ  per-requester ready
- req_prdata_o  out  NUM_REQ x APB_DATA_WIDTH  per-requester read data
- req_pslverr_o  out  NUM_REQ  per-requester error
- paddr_o, pwdata_o, pwrite_o, pstrb_o, pprot_o  out  as above  downstream payload
- psel_o  out  1  downstream select
- penable_o  out  1  downstream enable
- pready_i  in  1  downstream ready
- prdata_i  in  APB_DATA_WIDTH  downstream read data
- pslverr_i  in  1  downstream error
- busy_o  out  1  transfer in flight (state != IDLE)
- grant_idx_o  out  $clog2(NUM_REQ)  index of last/current grant
- timeout_o  out  1  single-cycle pulse when a transfer times out

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE: if any req_psel_i, grant the first set index strictly after the rr pointer (wrapping). Latch that requester's paddr/pwdata/pwrite/pstrb/pprot into the payload registers, store the grant index, go to SETUP. Otherwise stay in IDLE.
  - SETUP: psel_o=1, penable_o=0. Clear the timeout counter. Go to ACCESS unconditionally.
  - ACCESS: psel_o=1, penable_o=1, counter increments each cycle.
    - If pready_i: combinationally drive the granted requester with req_pready_o=1, req_prdata_o=prdata_i, req_pslverr_o=pslverr_i. Set rr pointer = grant index. Go to IDLE.
    - Else if TIMEOUT_CYCLES!=0 and counter == TIMEOUT_CYCLES-1: drive the granted requester with req_pready_o=1, req_pslverr_o=1, req_prdata_o=0. Pulse timeout_o. Update rr pointer. Go to IDLE. psel_o/penable_o drop in the next cycle.
- Simultaneous pready_i and timeout expiry: pready_i wins; normal completion, no timeout_o.
- Non-granted requesters and all requesters outside ACCESS completion see req_pready_o=0, req_prdata_o=0, req_pslverr_o=0. They are stalled in their own ACCESS phase, which is legal APB.
- Latency: a requester sees completion no earlier than 2 cycles after the arbiter samples its psel in IDLE (IDLE->SETUP->ACCESS with zero-wait slave). Back-to-back transfers from one requester take 3 cycles each.
- Payload outputs hold the latched values from SETUP until the next grant; they are don't-care but stable while psel_o=0.
- Requester deasserts psel mid-transfer (protocol violation): the downstream transfer still completes or times out; the response is discarded; no other effect.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. Downstream sees psel_o drop with no handshake; this is accepted.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0...
- Timeout counter saturates and never wraps.

Decomposition:
- Shared package apb_periph_arb_pkg:
  - arb_state_e {IDLE, SETUP, ACCESS}
  - DefaultTimeoutCycles constant
- One sub-module apb_arb_rr_pick: combinational round-robin picker.
  - Inputs: request vector, rr pointer.
  - Outputs: grant index, valid.
- FSM, payload registers and timeout counter stay in the top module.

Test Plan:
- Single requester 0 writes 0xDEADBEEF to 0x1A10_0004, slave pready immediate -> psel_o high cycles 1-2, penable_o cycle 2, req_pready_o[0] pulse in cycle 2, pwdata_o=0xDEADBEEF, grant_idx_o=0.
- Requesters 0 and 1 both request continuously for 6 transfers -> grant order 0,1,0,1,0,1, and each non-granted requester's pready stays 0 while waiting.
- Read with slave inserting 5 wait states, prdata_i=0x1234_5678, pslverr_i=1 -> requester receives 0x12345678 and pslverr=1 on the completion cycle only.
- TIMEOUT_CYCLES=8, slave never asserts pready -> after 8 ACCESS cycles: req_pready_o=1, req_pslverr_o=1, req_prdata_o=0, timeout_o 1-cycle pulse, FSM back in IDLE; next request is served normally.
- TIMEOUT_CYCLES=8, pready_i asserted in exactly the 8th ACCESS cycle -> normal completion with slave data, timeout_o stays 0.
- rst_ni asserted during ACCESS -> same-cycle psel_o/penable_o/busy_o=0; after release, requester 0 has priority.

Source files
------------

// File: rtl/apb_periph_arb_pkg.sv
// Shared types and constants for the APB peripheral-port arbiter.
package apb_periph_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam int unsigned DefaultTimeoutCycles = 1024;

endpackage

// File: rtl/apb_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
module apb_arb_rr_pick #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       valid_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  int unsigned cand;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    cand    = 0;
    // Offset NUM_REQ wraps back onto the pointer itself, so it has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        grant_o = IdxW'(cand);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_periph_arbiter.sv
// Round-robin arbiter sharing one APB slave port among NUM_REQ requesters,
// one transfer in flight, with an optional ACCESS-phase response timeout.
module apb_periph_arbiter
  import apb_periph_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NUM_REQ-1:0][APB_ADDR_WIDTH-1:0]        req_paddr_i,
  input  logic [NUM_REQ-1:0][APB_DATA_WIDTH-1:0]        req_pwdata_i,
  input  logic [NUM_REQ-1:0]                            req_pwrite_i,
  input  logic [NUM_REQ-1:0][APB_DATA_WIDTH/8-1:0]      req_pstrb_i,
  input  logic [NUM_REQ-1:0][2:0]                       req_pprot_i,
  input  logic [NUM_REQ-1:0]                            req_psel_i,
  input  logic [NUM_REQ-1:0]                            req_penable_i,
  output logic [NUM_REQ-1:0]                            req_pready_o,
  output logic [NUM_REQ-1:0][APB_DATA_WIDTH-1:0]        req_prdata_o,
  output logic [NUM_REQ-1:0]                            req_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]                     paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                     pwdata_o,
  output logic                                          pwrite_o,
  output logic [APB_DATA_WIDTH/8-1:0]                   pstrb_o,
  output logic [2:0]                                    pprot_o,
  output logic                                          psel_o,
  output logic                                          penable_o,
  input  logic                                          pready_i,
  input  logic [APB_DATA_WIDTH-1:0]                     prdata_i,
  input  logic                                          pslverr_i,
  output logic                                          busy_o,
  output logic [$clog2(NUM_REQ)-1:0]                    grant_idx_o,
  output logic                                          timeout_o
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned StrbW = APB_DATA_WIDTH / 8;
  localparam bit          ToEn  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] ToLast =
    ToEn ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e               state_q, state_d;
  logic [IdxW-1:0]          rr_q, rr_d;
  logic [IdxW-1:0]          gnt_q, gnt_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                     pwrite_q, pwrite_d;
  logic [StrbW-1:0]         pstrb_q, pstrb_d;
  logic [2:0]               pprot_q, pprot_d;

  logic [IdxW-1:0]          pick_idx;
  logic                     pick_vld;

  // Requester PENABLE carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = ^req_penable_i;

  apb_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (req_psel_i),
    .ptr_i   (rr_q),
    .grant_o (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    req_pready_o  = '0;
    req_prdata_o  = '0;
    req_pslverr_o = '0;
    timeout_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d    = pick_idx;
          paddr_d  = req_paddr_i[pick_idx];
          pwdata_d = req_pwdata_i[pick_idx];
          pwrite_d = req_pwrite_i[pick_idx];
          pstrb_d  = req_pstrb_i[pick_idx];
          pprot_d  = req_pprot_i[pick_idx];
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
        // A ready slave always beats an expiring timer in the same cycle.
        if (pready_i) begin
          req_pready_o[gnt_q]  = 1'b1;
          req_prdata_o[gnt_q]  = prdata_i;
          req_pslverr_o[gnt_q] = pslverr_i;
          rr_d                 = gnt_q;
          state_d              = IDLE;
        end else if (ToEn && (cnt_q == ToLast)) begin
          req_pready_o[gnt_q]  = 1'b1;
          req_pslverr_o[gnt_q] = 1'b1;
          timeout_o            = 1'b1;
          rr_d                 = gnt_q;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_q     <= IdxW'(NUM_REQ - 1);
      gnt_q    <= '0;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
    end
  end

  assign psel_o      = (state_q != IDLE);
  assign penable_o   = (state_q == ACCESS);
  assign busy_o      = (state_q != IDLE);
  assign grant_idx_o = gnt_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pwrite_o    = pwrite_q;
  assign pstrb_o     = pstrb_q;
  assign pprot_o     = pprot_q;

endmodule
